// File: rtl/line_bank_scheduler.sv
// Ping-pong line-bank controller: producer fills one BRAM bank while scanout
// reads the other, repeating each produced line REPEAT times.
module line_bank_scheduler #(
  parameter int LINE_LEN = 640,
  parameter int ADDR_W   = 10,
  parameter int REPEAT   = 2
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              wr_line_start,
  input  logic              wr_valid,
  input  logic              rd_line_start,
  input  logic              rd_active,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  output logic              line_req,
  output logic              underrun,
  output logic              overrun
);

  // state | meaning
  // IDLE  | waiting for the first frame_start
  // FILL  | first line of the frame being written; swap as soon as it completes
  // RUN   | steady state; swaps only at scanout line starts

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LINE_LEN - 1);
  localparam logic [1:0]        REP_LAST  = 2'(REPEAT - 1);

  state_t     state, state_nxt;
  logic       writing, wr_done;
  logic [1:0] rep_cnt;
  logic       do_swap, do_rep_inc, do_underrun;

  assign wr_en = wr_valid & writing;

  always_comb begin
    state_nxt   = state;
    do_swap     = 1'b0;
    do_rep_inc  = 1'b0;
    do_underrun = 1'b0;
    if (frame_start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        FILL: begin
          if (wr_done) begin
            do_swap   = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (rd_line_start) begin
            if (rep_cnt < REP_LAST) do_rep_inc  = 1'b1;
            else if (wr_done)       do_swap     = 1'b1;
            else                    do_underrun = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      writing  <= 1'b0;
      wr_done  <= 1'b0;
      rep_cnt  <= 2'd0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b1;
      line_req <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      line_req <= frame_start | do_swap;

      if (rd_line_start)
        rd_addr <= '0;
      else if (rd_active && rd_addr != ADDR_LAST)
        rd_addr <= rd_addr + 1'b1;

      if (frame_start) begin
        writing <= 1'b0;
        wr_done <= 1'b0;
        rep_cnt <= 2'd0;
        wr_addr <= '0;
      end else begin
        // wr_done/writing seen here are pre-swap values, so a line start
        // coinciding with a swap is rejected as an overrun.
        if (wr_line_start) begin
          if (!writing && !wr_done) begin
            writing <= 1'b1;
            wr_addr <= '0;
          end else begin
            overrun <= 1'b1;
          end
        end
        if (wr_valid && !writing) overrun <= 1'b1;
        if (wr_en) begin
          if (wr_addr == ADDR_LAST) begin
            writing <= 1'b0;
            wr_done <= 1'b1;
            wr_addr <= '0;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        if (do_swap) begin
          wr_bank <= ~wr_bank;
          rd_bank <= wr_bank;
          wr_done <= 1'b0;
          rep_cnt <= 2'd0;
        end
        if (do_rep_inc)  rep_cnt  <= rep_cnt + 2'd1;
        if (do_underrun) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Directed bench for line_bank_scheduler with hand-computed expectations
// (LINE_LEN=640, REPEAT=2).
module tb_line_bank_scheduler;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0, wr_line_start = 1'b0, wr_valid = 1'b0;
  logic       rd_line_start = 1'b0, rd_active = 1'b0;
  logic       wr_en, wr_bank, rd_bank, line_req, underrun, overrun;
  logic [9:0] wr_addr, rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  line_bank_scheduler #(.LINE_LEN(640), .ADDR_W(10), .REPEAT(2)) dut (
    .pclk(pclk), .rst(rst), .frame_start(frame_start),
    .wr_line_start(wr_line_start), .wr_valid(wr_valid),
    .rd_line_start(rd_line_start), .rd_active(rd_active),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_addr(rd_addr), .rd_bank(rd_bank), .line_req(line_req),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Drives n accepted pixels, checking the write strobe and address of each.
  task automatic write_pixels(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      #1;
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, base + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic pulse_wr_line();
    wr_line_start = 1'b1;
    tick();
    wr_line_start = 1'b0;
  endtask

  task automatic pulse_rd_line();
    rd_line_start = 1'b1;
    tick();
    rd_line_start = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_line_req", line_req, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // First line of the frame: FILL swaps without any rd_line_start.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs_line_req", line_req, 1);
    tick();
    chk("fs_line_req_low", line_req, 0);
    pulse_wr_line();
    write_pixels(640, 0);
    chk("fill_wr_addr_wrap", wr_addr, 0);
    chk("fill_pre_swap_bank", wr_bank, 0);
    tick();
    chk("fill_swap_wr_bank", wr_bank, 1);
    chk("fill_swap_rd_bank", rd_bank, 0);
    chk("fill_swap_line_req", line_req, 1);
    tick();
    chk("fill_line_req_low", line_req, 0);

    // RUN: first rd_line_start only repeats; rd_addr counts and saturates.
    pulse_rd_line();
    chk("run_rep_wr_bank", wr_bank, 1);
    chk("run_rep_line_req", line_req, 0);
    chk("run_rd_addr0", rd_addr, 0);
    rd_active = 1'b1;
    tick();
    chk("run_rd_addr1", rd_addr, 1);
    repeat (699) tick();
    rd_active = 1'b0;
    chk("run_rd_addr_sat", rd_addr, 639);
    pulse_wr_line();
    write_pixels(640, 0);
    pulse_rd_line();
    chk("run_swap_wr_bank", wr_bank, 0);
    chk("run_swap_rd_bank", rd_bank, 1);
    chk("run_swap_line_req", line_req, 1);
    chk("run_swap_rd_addr", rd_addr, 0);
    chk("run_underrun0", underrun, 0);
    tick();
    chk("run_line_req_low", line_req, 0);

    // Producer stall at a due swap.
    pulse_rd_line();
    chk("stall_rep_wr_bank", wr_bank, 0);
    pulse_wr_line();
    write_pixels(300, 0);
    pulse_rd_line();
    chk("stall_underrun", underrun, 1);
    chk("stall_wr_bank", wr_bank, 0);
    chk("stall_rd_bank", rd_bank, 1);
    chk("stall_line_req", line_req, 0);
    write_pixels(340, 300);
    tick();
    chk("stall_no_early_swap", wr_bank, 0);
    pulse_rd_line();
    chk("stall_swap_wr_bank", wr_bank, 1);
    chk("stall_swap_rd_bank", rd_bank, 0);
    chk("stall_swap_line_req", line_req, 1);

    // 641 pixels: the extra one is not written and flags overrun.
    chk("ovr_pre", overrun, 0);
    pulse_wr_line();
    write_pixels(640, 0);
    chk("ovr_after_640", overrun, 0);
    wr_valid = 1'b1;
    #1;
    chk("ovr_641_wr_en", wr_en, 0);
    tick();
    wr_valid = 1'b0;
    chk("ovr_641_flag", overrun, 1);

    // frame_start mid-line coincident with rd_line_start.
    pulse_rd_line();
    pulse_rd_line();
    chk("mid_pre_swap_wr_bank", wr_bank, 0);
    pulse_wr_line();
    write_pixels(200, 0);
    chk("mid_wr_addr200", wr_addr, 200);
    frame_start = 1'b1;
    rd_line_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rd_line_start = 1'b0;
    chk("mid_fs_wr_addr", wr_addr, 0);
    chk("mid_fs_wr_bank", wr_bank, 0);
    chk("mid_fs_line_req", line_req, 1);
    tick();
    chk("mid_fs_line_req_low", line_req, 0);
    pulse_wr_line();
    write_pixels(640, 0);
    tick();
    chk("mid_fill_swap_wr_bank", wr_bank, 1);
    chk("mid_fill_swap_line_req", line_req, 1);

    // Stray pixel with no granted line, from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_overrun", overrun, 0);
    chk("rst2_underrun", underrun, 0);
    wr_valid = 1'b1;
    #1;
    chk("stray_wr_en", wr_en, 0);
    tick();
    wr_valid = 1'b0;
    chk("stray_overrun", overrun, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
